// File: rtl/apb_mem_completer.sv
// APB completer backed by a byte-wide register memory.
// It inserts a fixed number of wait states, flags out-of-range addresses with pslverr,
// and keeps a sticky flag for bridge protocol violations.
module apb_mem_completer #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 192,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  proto_err,
  output logic [7:0]            txn_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] cap_addr, cap_addr_n;
  logic                  cap_write, cap_write_n;
  logic [DATA_WIDTH-1:0] cap_wdata, cap_wdata_n;
  logic                  pready_n;
  logic [DATA_WIDTH-1:0] prdata_n;
  logic                  pslverr_n;
  logic                  proto_err_n;
  logic [7:0]            txn_count_n;

  logic                  mem_we_c;
  logic                  resp_load_c;
  logic [ADDR_WIDTH-1:0] resp_addr_c;
  logic                  resp_write_c;
  logic                  resp_in_range_c;
  logic                  cap_in_range_c;
  logic                  unstable_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Address range decode and bus-stability comparison against the captured request
  always_comb begin
    cap_in_range_c = ({1'b0, cap_addr} < DEPTH_LIM);
    unstable_c     = (paddr != cap_addr) || (pwrite != cap_write) ||
                     (cap_write && (pwdata != cap_wdata));
  end

  // Next-state, capture, response and counter logic
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cap_addr_n   = cap_addr;
    cap_write_n  = cap_write;
    cap_wdata_n  = cap_wdata;
    pready_n     = 1'b0;
    prdata_n     = '0;
    pslverr_n    = 1'b0;
    proto_err_n  = proto_err;
    txn_count_n  = txn_count;
    mem_we_c     = 1'b0;
    resp_load_c  = 1'b0;
    resp_addr_c  = cap_addr;
    resp_write_c = cap_write;

    case (state)
      IDLE: begin
        if (psel && !penable) begin
          cap_addr_n  = paddr;
          cap_write_n = pwrite;
          cap_wdata_n = pwdata;
          cnt_n       = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            // Zero wait states: the response comes straight from the setup-phase bus
            state_n      = DONE;
            resp_load_c  = 1'b1;
            resp_addr_c  = paddr;
            resp_write_c = pwrite;
          end else begin
            state_n = WAIT;
          end
        end else if (psel && penable) begin
          proto_err_n = 1'b1;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_n     = IDLE;
          proto_err_n = 1'b1;
        end else begin
          if (unstable_c) proto_err_n = 1'b1;
          if (penable) begin
            if (cnt <= CNT_W'(1)) begin
              state_n     = DONE;
              resp_load_c = 1'b1;
            end else begin
              cnt_n = cnt - CNT_W'(1);
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        if (!psel) begin
          proto_err_n = 1'b1;
        end else begin
          if (unstable_c) proto_err_n = 1'b1;
          if (penable) begin
            mem_we_c = cap_write && cap_in_range_c;
            if (!pslverr) txn_count_n = txn_count + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    resp_in_range_c = ({1'b0, resp_addr_c} < DEPTH_LIM);
    if (resp_load_c) begin
      pready_n = 1'b1;
      if (!resp_in_range_c) begin
        pslverr_n = 1'b1;
      end else if (!resp_write_c) begin
        prdata_n = mem[IDX_W'(resp_addr_c)];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
      proto_err <= 1'b0;
      txn_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cap_addr  <= cap_addr_n;
      cap_write <= cap_write_n;
      cap_wdata <= cap_wdata_n;
      pready    <= pready_n;
      prdata    <= prdata_n;
      pslverr   <= pslverr_n;
      proto_err <= proto_err_n;
      txn_count <= txn_count_n;
    end
  end

  // Storage array; a write commits only at the completion edge of an in-range write
  always_ff @(posedge pclk) begin
    if (mem_we_c) mem[IDX_W'(cap_addr)] <= cap_wdata;
  end

endmodule

// File: tb/tb_apb_mem_completer.sv
// Scoreboard bench for apb_mem_completer: u0 has two wait states, u1 has none.
module tb_apb_mem_completer;

  logic            pclk = 1'b0;
  logic            presetn;
  logic [1:0]      psel, penable, pwrite;
  logic [1:0][7:0] paddr, pwdata;
  logic [1:0]      pready, pslverr, proto_err;
  logic [1:0][7:0] prdata, txn_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] e0, e1;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_mem_completer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(192), .WAIT_STATES(2)) u0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0]),
    .pslverr(pslverr[0]), .proto_err(proto_err[0]), .txn_count(txn_count[0]));

  apb_mem_completer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(192), .WAIT_STATES(0)) u1 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1]),
    .pslverr(pslverr[1]), .proto_err(proto_err[1]), .txn_count(txn_count[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every pready pulse pops one expected {pslverr, prdata}
  always @(negedge pclk) begin
    if (pready[0] === 1'b1) begin
      if (q0.size() == 0) begin
        check("u0_unexpected_pready", 32'(pready[0]), 32'd0);
      end else begin
        e0 = q0.pop_front();
        check("u0_pslverr", 32'(pslverr[0]), 32'(e0[8]));
        check("u0_prdata", 32'(prdata[0]), 32'(e0[7:0]));
      end
    end
  end

  always @(negedge pclk) begin
    if (pready[1] === 1'b1) begin
      if (q1.size() == 0) begin
        check("u1_unexpected_pready", 32'(pready[1]), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("u1_pslverr", 32'(pslverr[1]), 32'(e1[8]));
        check("u1_prdata", 32'(prdata[1]), 32'(e1[7:0]));
      end
    end
  end

  task automatic push(input int d, input logic err, input logic [7:0] data);
    if (d == 0) q0.push_back({err, data});
    else        q1.push_back({err, data});
  endtask

  // One transfer left with psel high at the pready cycle, so calls can chain back-to-back
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                      input logic err, input logic [7:0] rd, output int done_cyc);
    int n;
    int ws;
    ws = (d == 0) ? 2 : 0;
    @(negedge pclk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    push(d, err, (wr || err) ? 8'h00 : rd);
    @(negedge pclk);
    penable[d] = 1'b1;
    n = 1;
    while (pready[d] !== 1'b1 && n <= 20) begin
      @(negedge pclk);
      n++;
    end
    check($sformatf("u%0d_latency_a%0h", d, a), 32'(n), 32'(ws + 1));
    done_cyc = cyc;
  endtask

  task automatic idle(input int d);
    @(negedge pclk);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic do_reset();
    presetn = 1'b0; psel = '0; penable = '0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, c3;
    presetn = 1'b0;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
    do_reset();

    // Reset state of both instances
    @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("u%0d_rst_pready", d), 32'(pready[d]), 32'd0);
      check($sformatf("u%0d_rst_prdata", d), 32'(prdata[d]), 32'd0);
      check($sformatf("u%0d_rst_pslverr", d), 32'(pslverr[d]), 32'd0);
      check($sformatf("u%0d_rst_proto", d), 32'(proto_err[d]), 32'd0);
      check($sformatf("u%0d_rst_count", d), 32'(txn_count[d]), 32'd0);
    end

    // Basic write then read
    xfer(0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, c0);
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, c0);
    idle(0);
    check("u0_count_after_rw", 32'(txn_count[0]), 32'd2);

    // Out-of-range write and read
    xfer(0, 1'b1, 8'hC5, 8'h3C, 1'b1, 8'h00, c0);
    idle(0);
    xfer(0, 1'b0, 8'hC5, 8'h00, 1'b1, 8'h00, c0);
    idle(0);
    check("u0_count_after_err", 32'(txn_count[0]), 32'd2);

    // Back-to-back with read-after-write
    xfer(0, 1'b1, 8'h00, 8'h11, 1'b0, 8'h00, c0);
    xfer(0, 1'b1, 8'h01, 8'h22, 1'b0, 8'h00, c1);
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, c2);
    xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h22, c3);
    idle(0);
    check("u0_b2b_spacing1", 32'(c1 - c0), 32'd4);
    check("u0_b2b_spacing3", 32'(c3 - c2), 32'd4);
    check("u0_count_after_b2b", 32'(txn_count[0]), 32'd6);
    check("u0_proto_clean", 32'(proto_err[0]), 32'd0);

    // Abort in second wait cycle leaves memory untouched
    xfer(0, 1'b1, 8'h20, 8'h5A, 1'b0, 8'h00, c0);
    idle(0);
    @(negedge pclk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h20; pwdata[0] = 8'h77;
    @(negedge pclk); penable[0] = 1'b1;
    @(negedge pclk); psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge pclk);
    check("u0_abort_pready", 32'(pready[0]), 32'd0);
    check("u0_abort_proto", 32'(proto_err[0]), 32'd1);
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h5A, c0);
    idle(0);
    check("u0_count_after_abort", 32'(txn_count[0]), 32'd8);

    // Access phase without setup
    do_reset();
    @(negedge pclk);
    check("u0_proto_after_reset", 32'(proto_err[0]), 32'd0);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 8'h00;
    @(negedge pclk);
    check("u0_nosetup_proto", 32'(proto_err[0]), 32'd1);
    check("u0_nosetup_pready", 32'(pready[0]), 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;

    // Address changes mid-wait: captured address is still used
    do_reset();
    xfer(0, 1'b1, 8'h31, 8'h00, 1'b0, 8'h00, c0);
    idle(0);
    @(negedge pclk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h30; pwdata[0] = 8'h99;
    push(0, 1'b0, 8'h00);
    @(negedge pclk); penable[0] = 1'b1;
    @(negedge pclk); paddr[0] = 8'h31;
    @(negedge pclk);
    check("u0_unstable_pready", 32'(pready[0]), 32'd1);
    idle(0);
    check("u0_unstable_proto", 32'(proto_err[0]), 32'd1);
    xfer(0, 1'b0, 8'h30, 8'h00, 1'b0, 8'h99, c0);
    xfer(0, 1'b0, 8'h31, 8'h00, 1'b0, 8'h00, c0);
    idle(0);

    // Reset asserted during WAIT clears outputs at once and drops the write
    xfer(0, 1'b1, 8'h40, 8'h01, 1'b0, 8'h00, c0);
    idle(0);
    @(negedge pclk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h40; pwdata[0] = 8'hEE;
    @(negedge pclk); penable[0] = 1'b1;
    check("u0_count_before_rst", 32'(txn_count[0]), 32'd5);
    #2 presetn = 1'b0;
    #1;
    check("u0_midrst_count", 32'(txn_count[0]), 32'd0);
    check("u0_midrst_proto", 32'(proto_err[0]), 32'd0);
    check("u0_midrst_pready", 32'(pready[0]), 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge pclk); presetn = 1'b1;
    xfer(0, 1'b0, 8'h40, 8'h00, 1'b0, 8'h01, c0);
    idle(0);

    // Zero-wait instance: 256 OKAY writes wrap the counter
    for (int i = 0; i < 256; i++) begin
      xfer(1, 1'b1, 8'(i % 192), 8'(i), 1'b0, 8'h00, c0);
    end
    idle(1);
    check("u1_count_wrap", 32'(txn_count[1]), 32'd0);
    xfer(1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hC5, c0);
    xfer(1, 1'b0, 8'hC8, 8'h00, 1'b1, 8'h00, c0);
    idle(1);
    check("u1_count_after_wrap", 32'(txn_count[1]), 32'd1);
    check("u1_proto_clean", 32'(proto_err[1]), 32'd0);

    repeat (2) @(negedge pclk);
    check("u0_queue_drained", 32'(q0.size()), 32'd0);
    check("u1_queue_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_mem_completer.md
Name: apb_mem_completer

Overview:
- APB completer (slave end) for the 2-slave APB subsystem. It answers the bridge's PSEL/PENABLE phases for one slave port.
- Backed by an internal byte-wide register memory, with a fixed, parameterised number of wait states, PSLVERR for out-of-range addresses, and a sticky protocol-violation flag.
- Instantiated once per slave behind the bridge. Bridge address bit 8 selects which instance receives PSEL.

Parameters:
- ADDR_WIDTH, 8, width of paddr.
- DATA_WIDTH, 8, width of pwdata/prdata.
- DEPTH, 192, number of implemented locations. Legal addresses are 0..DEPTH-1. Requires DEPTH <= 2**ADDR_WIDTH.
- WAIT_STATES, 2, number of access-phase cycles with pready=0 before completion. Range 0..15.

Ports:
- pclk  input  1  APB clock; all logic rises on posedge.
- presetn  input  1  asynchronous active-low reset.
- psel  input  1  slave select from bridge.
- penable  input  1  access-phase strobe.
- pwrite  input  1  1=write, 0=read.
- paddr  input  ADDR_WIDTH  byte address.
- pwdata  input  DATA_WIDTH  write data.
- pready  output  1  transfer-complete strobe.
- prdata  output  DATA_WIDTH  read data, valid only while pready=1.
- pslverr  output  1  error response, valid only while pready=1.
- proto_err  output  1  sticky protocol-violation flag.
- txn_count  output  8  count of OKAY transfers completed.

Behaviour:
- Interface decision: reset presetn, asynchronous, active-low; clock pclk.
- Reset values: pready=0, prdata=0, pslverr=0, proto_err=0, txn_count=0, FSM=IDLE. Memory contents are not reset.
- Reset mid-transfer aborts the transfer with no memory write.
- All outputs are registered.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Edge samples psel=1, penable=0 (setup): capture paddr, pwrite, pwdata; load wait counter with WAIT_STATES.
  - If WAIT_STATES=0, go to DONE and register the response in the same edge. Otherwise go to WAIT.
  - Edge samples psel=1, penable=1 (access with no setup): set proto_err, stay IDLE, no response.
- WAIT:
  - Each edge with psel=1, penable=1 decrements the counter.
  - When the counter reaches 1 at an edge, go to DONE and register the response at that edge.
  - Result: pready rises in access cycle WAIT_STATES+1, so the total transfer takes WAIT_STATES+2 cycles including setup.
- Response (registered on entry to DONE), with A = captured address:
  - A >= DEPTH: pslverr=1, prdata=0.
  - Read with A < DEPTH: prdata=mem[A], pslverr=0.
  - Write: prdata=0, pslverr=0.
- DONE:
  - pready=1 for exactly one cycle.
  - At the completion edge (psel=1, penable=1, pready=1):
    - Write with A < DEPTH commits captured pwdata to mem[A].
    - If pslverr=0, txn_count increments, wrapping 255->0.
  - Next state is IDLE. pready, pslverr and prdata return to 0 in the following cycle.
  - Writes to addresses >= DEPTH are discarded.
- Abort: psel=0 sampled in WAIT or DONE (before completion) -> return to IDLE, no write, no count, proto_err set, outputs cleared.
- Stability check: in WAIT/DONE, if paddr, pwrite or (for writes) pwdata differ from the captured values, set proto_err. The transfer still completes using the captured values.
- Back-to-back: an edge in IDLE immediately after completion may sample a new setup phase. Minimum spacing between completions is WAIT_STATES+2 cycles.
- proto_err clears only on reset.
- Read-after-write to the same address in consecutive transfers returns the new data. The write commits before the next transfer's response is registered.

Test Plan:
- Reset, then write 0xA5 to 0x10 (WAIT_STATES=2) -> pready low for 2 access cycles, high on the 3rd. Read 0x10 -> prdata=0xA5, pslverr=0, txn_count=2.
- Write 0x3C to 0xC5 (>= DEPTH=192) -> pready with pslverr=1, txn_count unchanged. Read 0xC5 -> pslverr=1, prdata=0x00.
- Back-to-back: write 0x11 to 0x00, write 0x22 to 0x01, read 0x00, read 0x01 with no idle cycles -> prdata 0x11 then 0x22, completions 4 cycles apart.
- Drop psel during second wait cycle of a write of 0x77 to 0x20 -> no pready, proto_err=1. A later read of 0x20 returns the previous contents.
- penable=1 with psel=1 from IDLE -> proto_err=1, no pready. Separately, change paddr mid-wait -> proto_err=1 and the captured address is used.
- Assert presetn=0 during WAIT -> all outputs 0 immediately, no write. Separately, 256 OKAY transfers -> txn_count wraps to 0x00. Also run with WAIT_STATES=0 -> pready in the first access cycle.
